biquad_coeff_loader: RTL and testbench

BIQUAD_COEFF_LOADER -- requirements
Module: biquad_coeff_loader

---
 rtl/biquad_loader_pkg.sv | 31 +++
 rtl/biquad_coeff_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_biquad_coeff_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biquad_loader_pkg.sv
// ---------------------------------------------------------------------------
// biquad_loader_pkg
//   Shared definitions for the biquad coefficient loader:
//     loader_state_t  - controller states (IDLE, WR, RD, GAP, UPD)
//     ERR_CODE_*      - values reported on err_code_o
//     STAGE_SEL_BIT   - address bit that selects the biquad stage
//   stage_of() pulls the stage-select bit out of a coefficient address.
// ---------------------------------------------------------------------------
package biquad_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,  // waiting for a coefficient write request
    WR   = 3'd1,  // Wishbone write strobe outstanding
    RD   = 3'd2,  // verify read strobe outstanding
    GAP  = 3'd3,  // one bus-idle cycle before (re)issuing a strobe
    UPD  = 3'd4   // commit pulse after the last word of a set
  } loader_state_t;

  localparam logic [1:0] ERR_CODE_NONE    = 2'b00;
  localparam logic [1:0] ERR_CODE_BUS     = 2'b01;  // bus error or retries exhausted
  localparam logic [1:0] ERR_CODE_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_CODE_VERIFY  = 2'b11;

  // Address bit 7 chooses which biquad stage a coefficient belongs to.
  localparam int unsigned STAGE_SEL_BIT = 7;

  function automatic logic stage_of(input logic [7:0] adr);
    return adr[STAGE_SEL_BIT];
  endfunction

endpackage

// File: rtl/biquad_coeff_loader.sv
// ---------------------------------------------------------------------------
// biquad_coeff_loader
//   Takes coefficient write requests and performs each one as a Wishbone
//   classic write, optionally followed by a read-back compare. Retries on
//   wb_rty_i, aborts on error or timeout, and pulses notch_update_o/done_o
//   once the final word of a coefficient set has landed cleanly.
//
// Ports
//   wb_clk_i, wb_rst_n_i       clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o    request handshake
//   cmd_adr_i, cmd_dat_i       coefficient address (bit 7 = stage) and word
//   cmd_last_i                 final word of a coefficient set
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
//                              Wishbone initiator outputs (sel fixed 4'hF)
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
//                              Wishbone target read data and terminations
//   notch_update_o, done_o     one-cycle pulses on a clean set completion
//   busy_o                     high whenever the controller is not in IDLE
//   err_o, err_code_o          sticky error flag and first error code
//   clr_i                      clears err_o / err_code_o only
//
// Handshake: a request transfers on a rising clock edge where cmd_valid_i
// and cmd_ready_o are both high. cmd_ready_o is registered and is high only
// in IDLE with no sticky error, so at most one request is ever in flight.
// The requester must hold address, data and last stable while valid is high.
//
// All outputs come from registers loaded from the next-state decode, so the
// bus controls change exactly one cycle after the decision that caused them.
// ---------------------------------------------------------------------------
module biquad_coeff_loader
  import biquad_loader_pkg::*;
#(
  parameter string WBCLKTYPE = "NONE",
  parameter int    VERIFY    = 1,
  parameter int    MAX_RETRY = 3,
  parameter int    TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic        cmd_last_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        notch_update_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  input  logic        clr_i
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  // The counter holds the number of already-elapsed silent strobe cycles, so
  // the abort decision is taken in the TIMEOUT-th strobe cycle.
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  // State and datapath registers
  loader_state_t     state_q, state_d;
  logic              rd_phase_q, rd_phase_d;  // next strobe from GAP is the read
  logic [RTY_W-1:0]  rty_q, rty_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [7:0]        adr_q;
  logic [31:0]       dat_q;
  logic              last_q;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  // Registered outputs
  logic              cyc_q, stb_q, we_q;
  logic              notch_q, done_q, busy_q, ready_q;

  // Decode helpers
  logic              accept;
  logic              fail;
  logic [1:0]        fail_code;
  logic              strobe_d;

  // -------------------------------------------------------------------------
  // Next-state decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rd_phase_d = rd_phase_q;
    rty_d      = rty_q;
    to_d       = '0;  // any cycle that does not extend a silent strobe restarts it
    accept     = 1'b0;
    fail       = 1'b0;
    fail_code  = ERR_CODE_NONE;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && ready_q) begin
          accept     = 1'b1;
          state_d    = WR;
          rd_phase_d = 1'b0;
          rty_d      = '0;
        end
      end

      WR, RD: begin
        // err outranks both ack and rty when they coincide.
        if (wb_err_i) begin
          fail      = 1'b1;
          fail_code = ERR_CODE_BUS;
        end else if (wb_rty_i) begin
          // The retry budget is shared by the write and its read-back.
          if (rty_q < RTY_LIMIT) begin
            rty_d   = rty_q + RTY_W'(1);
            state_d = GAP;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_CODE_BUS;
          end
        end else if (wb_ack_i) begin
          if ((state_q == WR) && (VERIFY != 0)) begin
            // Drop the cycle for one clock, then read the same address back.
            rd_phase_d = 1'b1;
            state_d    = GAP;
          end else if ((state_q == RD) && (wb_dat_i != dat_q)) begin
            fail      = 1'b1;
            fail_code = ERR_CODE_VERIFY;
          end else begin
            state_d = last_q ? UPD : IDLE;
          end
        end else if (to_q == TO_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_CODE_TIMEOUT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      GAP:     state_d = rd_phase_q ? RD : WR;
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fail) begin
      state_d = IDLE;
    end

    strobe_d = (state_d == WR) || (state_d == RD);
  end

  // -------------------------------------------------------------------------
  // Sticky error flags. A new error beats a simultaneous clear, and the first
  // recorded code is kept until software clears it.
  // -------------------------------------------------------------------------
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (clr_i) begin
      err_d  = 1'b0;
      code_d = ERR_CODE_NONE;
    end
    if (fail) begin
      err_d = 1'b1;
      if (!err_q || clr_i) begin
        code_d = fail_code;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      rd_phase_q <= 1'b0;
      rty_q      <= '0;
      to_q       <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_CODE_NONE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      notch_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_phase_q <= rd_phase_d;
      rty_q      <= rty_d;
      to_q       <= to_d;
      err_q      <= err_d;
      code_q     <= code_d;
      if (accept) begin
        adr_q  <= cmd_adr_i;
        dat_q  <= cmd_dat_i;
        last_q <= cmd_last_i;
      end
      cyc_q   <= strobe_d;
      stb_q   <= strobe_d;
      we_q    <= (state_d == WR);
      notch_q <= (state_d == UPD);
      done_q  <= (state_d == UPD);
      busy_q  <= (state_d != IDLE);
      ready_q <= (state_d == IDLE) && !err_d;
    end
  end

  assign cmd_ready_o    = ready_q;
  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = stb_q;
  assign wb_we_o        = we_q;
  assign wb_adr_o       = adr_q;
  assign wb_dat_o       = dat_q;
  assign wb_sel_o       = 4'hF;
  assign notch_update_o = notch_q;
  assign done_o         = done_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;
  assign err_code_o     = code_q;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_biquad_coeff_loader
//   Directed bench for biquad_coeff_loader with default parameters
//   (VERIFY=1, MAX_RETRY=3, TIMEOUT=255). Each table entry is one request plus
//   a scripted target response per strobe and the expected outcome. A small
//   target model answers each strobe in its second cycle. Hand-written
//   sequences cover reset values, clear-while-busy and reset mid-write.
// ---------------------------------------------------------------------------
module tb_biquad_coeff_loader;

  localparam logic [2:0] R_SIL    = 3'd0;  // never terminate
  localparam logic [2:0] R_ACK    = 3'd1;
  localparam logic [2:0] R_RTY    = 3'd2;
  localparam logic [2:0] R_ERR    = 3'd3;
  localparam logic [2:0] R_ACKERR = 3'd4;  // ack and err together

  localparam int NVEC = 10;

  typedef struct {
    logic [7:0]       adr;
    logic [31:0]      dat;
    logic             last;
    logic [4:0][2:0]  rsp;       // rsp[k] answers the k-th strobe
    logic [31:0]      rd_dat;    // value the target returns on reads
    logic             clr_term;  // pulse clr_i with the termination
    logic             exp_err;
    logic [1:0]       exp_code;
    int               exp_notch;
    int               exp_wr;
    int               exp_rd;
    int               exp_run;   // longest strobe run in cycles
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        wb_clk_i   = 1'b0;
  logic        wb_rst_n_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- DUT signals ----------------
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_adr_i   = '0;
  logic [31:0] cmd_dat_i   = '0;
  logic        cmd_last_i  = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i    = '0;
  logic        wb_ack_i    = 1'b0;
  logic        wb_err_i    = 1'b0;
  logic        wb_rty_i    = 1'b0;
  logic        notch_update_o, busy_o, done_o, err_o;
  logic [1:0]  err_code_o;
  logic        clr_i       = 1'b0;

  biquad_coeff_loader dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_n_i     (wb_rst_n_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_adr_i      (cmd_adr_i),
    .cmd_dat_i      (cmd_dat_i),
    .cmd_last_i     (cmd_last_i),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i),
    .wb_rty_i       (wb_rty_i),
    .notch_update_o (notch_update_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o),
    .clr_i          (clr_i)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];  // commanded words awaiting their write strobes
  vec_t        vecs[NVEC];

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] adr, input logic [31:0] dat, input logic last,
                              input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2,
                              input logic [2:0] r3, input logic [2:0] r4,
                              input logic [31:0] rd_dat, input logic clr_term,
                              input logic exp_err, input logic [1:0] exp_code,
                              input int exp_notch, input int exp_wr, input int exp_rd,
                              input int exp_run);
    vec_t v;
    v.adr = adr; v.dat = dat; v.last = last;
    v.rsp[0] = r0; v.rsp[1] = r1; v.rsp[2] = r2; v.rsp[3] = r3; v.rsp[4] = r4;
    v.rd_dat = rd_dat; v.clr_term = clr_term;
    v.exp_err = exp_err; v.exp_code = exp_code; v.exp_notch = exp_notch;
    v.exp_wr = exp_wr; v.exp_rd = exp_rd; v.exp_run = exp_run;
    return v;
  endfunction

  // ---------------- driver: one table entry ----------------
  task automatic run_vec(input vec_t v, input int idx);
    int         guard, strobes, wr_n, rd_n, hi_cnt, max_run, gap;
    int         notch_n, done_n, bad_attr, bad_after, bad_gap, blocked;
    logic       prev_stb, term_prev, fin;
    logic [2:0] r;

    strobes = 0; wr_n = 0; rd_n = 0; hi_cnt = 0; max_run = 0; gap = 0;
    notch_n = 0; done_n = 0; bad_attr = 0; bad_after = 0; bad_gap = 0; blocked = 0;
    prev_stb = 1'b0; term_prev = 1'b0; fin = 1'b0; guard = 0;

    check($sformatf("v%0d_ready_before", idx), cmd_ready_o, 1);
    exp_q.push_back(v.dat);
    wb_dat_i    = v.rd_dat;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.dat;
    cmd_last_i  = v.last;
    cmd_valid_i = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    check($sformatf("v%0d_accept_cyc", idx), {wb_cyc_o, wb_we_o}, 2'b11);
    check($sformatf("v%0d_accept_ready", idx), cmd_ready_o, 0);

    while (!fin) begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; clr_i = 1'b0;
      if (term_prev && wb_cyc_o) bad_after++;
      term_prev = 1'b0;
      if (notch_update_o) notch_n++;
      if (done_o) done_n++;
      if (wb_stb_o) begin
        if (!prev_stb) begin
          if (strobes > 0 && gap != 1) bad_gap++;
          hi_cnt = 0;
          if (wb_we_o) wr_n++; else rd_n++;
          strobes++;
        end
        hi_cnt++;
        if (hi_cnt > max_run) max_run = hi_cnt;
        if (wb_adr_o != v.adr || wb_sel_o != 4'hF || !wb_cyc_o ||
            (wb_we_o && wb_dat_o != exp_q[0])) bad_attr++;
        if (hi_cnt == 2) begin
          r = (strobes <= 5) ? v.rsp[strobes-1] : R_SIL;
          wb_ack_i = (r == R_ACK) || (r == R_ACKERR);
          wb_err_i = (r == R_ERR) || (r == R_ACKERR);
          wb_rty_i = (r == R_RTY);
          if (r != R_SIL) begin
            term_prev = 1'b1;
            clr_i     = v.clr_term;
          end
        end
        gap = 0;
      end else begin
        gap++;
      end
      prev_stb = wb_stb_o;
      if (!busy_o) begin
        fin = 1'b1;
      end else if (guard >= 2000) begin
        errors++;
        $display("FAIL v%0d_budget: still busy after %0d cycles, required idle", idx, guard);
        fin = 1'b1;
      end else begin
        @(negedge wb_clk_i);
        guard++;
      end
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; clr_i = 1'b0;
    void'(exp_q.pop_front());

    check($sformatf("v%0d_err", idx), err_o, v.exp_err);
    check($sformatf("v%0d_code", idx), err_code_o, v.exp_code);
    check($sformatf("v%0d_notch", idx), notch_n, v.exp_notch);
    check($sformatf("v%0d_done", idx), done_n, v.exp_notch);
    check($sformatf("v%0d_wr_strobes", idx), wr_n, v.exp_wr);
    check($sformatf("v%0d_rd_strobes", idx), rd_n, v.exp_rd);
    check($sformatf("v%0d_strobe_run", idx), max_run, v.exp_run);
    check($sformatf("v%0d_bus_attr", idx), bad_attr, 0);
    check($sformatf("v%0d_cyc_after_term", idx), bad_after, 0);
    check($sformatf("v%0d_gap", idx), bad_gap, 0);
    check($sformatf("v%0d_ready_after", idx), cmd_ready_o, !v.exp_err);

    if (v.exp_err) begin
      // A waiting request must stay blocked until the flag is cleared.
      cmd_valid_i = 1'b1;
      repeat (3) begin
        @(negedge wb_clk_i);
        if (wb_cyc_o || cmd_ready_o) blocked++;
      end
      cmd_valid_i = 1'b0;
      check($sformatf("v%0d_blocked", idx), blocked, 0);
      check($sformatf("v%0d_code_held", idx), err_code_o, v.exp_code);
      clr_i = 1'b1;
      @(negedge wb_clk_i);
      clr_i = 1'b0;
      check($sformatf("v%0d_clr_err", idx), {err_o, err_code_o}, 3'b000);
      check($sformatf("v%0d_clr_ready", idx), cmd_ready_o, 1);
    end
    @(negedge wb_clk_i);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    //            adr    dat            last r0        r1     r2     r3     r4     rd_dat         clr  err code  ntc wr rd run
    vecs[0] = mk(8'h84, 32'h0001_2345, 1, R_ACK,    R_ACK, R_SIL, R_SIL, R_SIL, 32'h0001_2345, 0,   0, 2'b00, 1, 1, 1, 2);
    vecs[1] = mk(8'h84, 32'h0001_2345, 1, R_ACK,    R_ACK, R_SIL, R_SIL, R_SIL, 32'h0001_2344, 0,   1, 2'b11, 0, 1, 1, 2);
    vecs[2] = mk(8'h10, 32'hCAFE_F00D, 1, R_RTY,    R_RTY, R_ACK, R_ACK, R_SIL, 32'hCAFE_F00D, 0,   0, 2'b00, 1, 3, 1, 2);
    vecs[3] = mk(8'h20, 32'h1234_5678, 1, R_RTY,    R_RTY, R_RTY, R_RTY, R_SIL, 32'h1234_5678, 0,   1, 2'b01, 0, 4, 0, 2);
    vecs[4] = mk(8'h30, 32'h0000_00A5, 1, R_SIL,    R_SIL, R_SIL, R_SIL, R_SIL, 32'h0000_0000, 0,   1, 2'b10, 0, 1, 0, 255);
    vecs[5] = mk(8'h84, 32'h55AA_55AA, 1, R_ACKERR, R_SIL, R_SIL, R_SIL, R_SIL, 32'h55AA_55AA, 0,   1, 2'b01, 0, 1, 0, 2);
    vecs[6] = mk(8'h05, 32'h0000_0001, 0, R_ACK,    R_ACK, R_SIL, R_SIL, R_SIL, 32'h0000_0001, 0,   0, 2'b00, 0, 1, 1, 2);
    vecs[7] = mk(8'h88, 32'h8765_4321, 1, R_ACK,    R_ERR, R_SIL, R_SIL, R_SIL, 32'h8765_4321, 0,   1, 2'b01, 0, 1, 1, 2);
    vecs[8] = mk(8'h0C, 32'h00FF_00FF, 1, R_RTY,    R_ACK, R_RTY, R_RTY, R_ACK, 32'h00FF_00FF, 0,   0, 2'b00, 1, 2, 3, 2);
    vecs[9] = mk(8'h90, 32'hDEAD_BEEF, 1, R_ERR,    R_SIL, R_SIL, R_SIL, R_SIL, 32'hDEAD_BEEF, 1,   1, 2'b01, 0, 1, 0, 2);

    // Reset values while reset is held.
    repeat (3) @(negedge wb_clk_i);
    check("rst_ready", cmd_ready_o, 0);
    check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("rst_flags", {notch_update_o, done_o, busy_o, err_o}, 4'b0000);
    check("rst_code", err_code_o, 2'b00);
    check("rst_adr", wb_adr_o, 8'h00);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_sel", wb_sel_o, 4'hF);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);
    check("rel_ready", cmd_ready_o, 1);
    check("rel_busy", busy_o, 0);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    // clr_i during a write leaves the bus cycle alone; then reset mid-write.
    cmd_adr_i   = 8'h81;
    cmd_dat_i   = 32'h0BAD_F00D;
    cmd_last_i  = 1'b1;
    cmd_valid_i = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    check("mid_wr_cyc", wb_cyc_o, 1);
    check("mid_wr_adr", wb_adr_o, 8'h81);
    clr_i = 1'b1;
    @(negedge wb_clk_i);
    clr_i = 1'b0;
    check("clr_no_abort_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
    check("clr_no_abort_busy", busy_o, 1);
    @(negedge wb_clk_i);
    #2;
    wb_rst_n_i = 1'b0;
    #1;
    check("async_rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("async_rst_flags", {busy_o, cmd_ready_o, err_o, notch_update_o}, 4'b0000);
    check("async_rst_adr_dat", {wb_adr_o, wb_dat_o}, 40'h0);
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);
    check("post_rst_ready", cmd_ready_o, 1);
    check("post_rst_cyc", wb_cyc_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, required completion within 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
